// File: rtl/rdma_ipudp_header_gen.sv
`timescale 1ns/1ps
// IPv4+UDP header generator: takes one metadata record, checksums the IPv4
// header over 5 cycles, then streams the 28-byte header as 7 big-endian words.
module rdma_ipudp_header_gen #(
    parameter logic [7:0] IP_TTL   = 8'd64,
    parameter logic [7:0] IP_PROTO = 8'd17
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [15:0] i_payload_len,
    input  logic [31:0] i_src_ip,
    input  logic [31:0] i_dst_ip,
    input  logic [15:0] i_src_port,
    input  logic [15:0] i_dst_port,
    input  logic [7:0]  i_flags,
    input  logic [7:0]  i_endpoint_id,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [31:0] o_tdata,
    output logic        o_tvalid,
    output logic        o_tlast,
    output logic [7:0]  o_tuser,
    input  logic        i_tready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CSUM = 2'd1,
        S_FOLD = 2'd2,
        S_EMIT = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Registered copy of the accepted metadata record
    logic [15:0] len_q;
    logic [31:0] sip_q;
    logic [31:0] dip_q;
    logic [15:0] sport_q;
    logic [15:0] dport_q;
    logic [7:0]  tos_q;
    logic [7:0]  user_q;

    logic [19:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] csum_q, csum_d;
    logic [2:0]  widx_q, widx_d;
    logic [15:0] ident_q, ident_d;

    logic        ready_q, ready_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic [31:0] tdata_q, tdata_d;
    logic [7:0]  tuser_q, tuser_d;

    logic        accept;
    logic        beat;
    logic        last_beat;
    logic [2:0]  nxt_idx;
    logic [15:0] tot_len;
    logic [15:0] udp_len;
    logic [15:0] pair_a;
    logic [15:0] pair_b;
    logic [19:0] acc_sum;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [31:0] hdr_word [8];

    assign accept    = i_valid & ready_q;
    assign beat      = tvalid_q & i_tready;
    assign last_beat = beat & (widx_q == 3'd6);
    assign nxt_idx   = widx_q + 3'd1;
    assign tot_len   = len_q + 16'd28;
    assign udp_len   = len_q + 16'd8;

    // Two 16-bit header words summed per CSUM cycle
    always_comb begin
        pair_a = 16'h0000;
        pair_b = 16'h0000;
        case (cnt_q)
            3'd0: begin pair_a = {8'h45, tos_q};      pair_b = tot_len;       end
            3'd1: begin pair_a = ident_q;             pair_b = 16'h4000;      end
            3'd2: begin pair_a = {IP_TTL, IP_PROTO};  pair_b = 16'h0000;      end
            3'd3: begin pair_a = sip_q[31:16];        pair_b = sip_q[15:0];   end
            default: begin pair_a = dip_q[31:16];     pair_b = dip_q[15:0];   end
        endcase
    end

    assign acc_sum = acc_q + {4'h0, pair_a} + {4'h0, pair_b};
    // Second fold can only see a carry of 1, so the result fits in 16 bits
    assign fold1   = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
    assign fold2   = fold1[15:0] + {15'd0, fold1[16]};

    always_comb begin
        hdr_word[0] = {8'h45, tos_q, tot_len};
        hdr_word[1] = {ident_q, 16'h4000};
        hdr_word[2] = {IP_TTL, IP_PROTO, csum_q};
        hdr_word[3] = sip_q;
        hdr_word[4] = dip_q;
        hdr_word[5] = {sport_q, dport_q};
        hdr_word[6] = {udp_len, 16'h0000};
        hdr_word[7] = 32'h0000_0000;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CSUM;
            S_CSUM:  if (cnt_q == 3'd4) state_d = S_FOLD;
            S_FOLD:  state_d = S_EMIT;
            S_EMIT:  if (last_beat) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        widx_d   = widx_q;
        ident_d  = ident_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        ready_d  = (state_d == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d = 20'd0;
                    cnt_d = 3'd0;
                end
            end
            S_CSUM: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 3'd1;
            end
            S_FOLD: begin
                csum_d   = ~fold2;
                tvalid_d = 1'b1;
                tlast_d  = 1'b0;
                tdata_d  = hdr_word[0];
                tuser_d  = user_q;
                widx_d   = 3'd0;
            end
            S_EMIT: begin
                if (last_beat) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    tdata_d  = 32'h0000_0000;
                    tuser_d  = 8'h00;
                    ident_d  = ident_q + 16'd1;
                end else if (beat) begin
                    widx_d  = nxt_idx;
                    tdata_d = hdr_word[nxt_idx];
                    tlast_d = (nxt_idx == 3'd6);
                end
            end
            default: begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            acc_q    <= 20'd0;
            cnt_q    <= 3'd0;
            csum_q   <= 16'h0000;
            widx_q   <= 3'd0;
            ident_q  <= 16'h0000;
            ready_q  <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= 32'h0000_0000;
            tuser_q  <= 8'h00;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            widx_q   <= widx_d;
            ident_q  <= ident_d;
            ready_q  <= ready_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            len_q   <= 16'h0000;
            sip_q   <= 32'h0000_0000;
            dip_q   <= 32'h0000_0000;
            sport_q <= 16'h0000;
            dport_q <= 16'h0000;
            tos_q   <= 8'h00;
            user_q  <= 8'h00;
        end else if (state_q == S_IDLE && accept) begin
            len_q   <= i_payload_len;
            sip_q   <= i_src_ip;
            dip_q   <= i_dst_ip;
            sport_q <= i_src_port;
            dport_q <= i_dst_port;
            tos_q   <= i_flags;
            user_q  <= i_endpoint_id;
        end
    end

    assign o_ready  = ready_q;
    assign o_tvalid = tvalid_q;
    assign o_tlast  = tlast_q;
    assign o_tdata  = tdata_q;
    assign o_tuser  = tuser_q;

endmodule

// File: tb/tb_rdma_ipudp_header_gen.sv
`timescale 1ns/1ps
// Bench for rdma_ipudp_header_gen: per-packet header words are derived from the
// IPv4/UDP field rules with a ones-complement checksum model.
module tb_rdma_ipudp_header_gen;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [15:0] i_payload_len;
    logic [31:0] i_src_ip;
    logic [31:0] i_dst_ip;
    logic [15:0] i_src_port;
    logic [15:0] i_dst_port;
    logic [7:0]  i_flags;
    logic [7:0]  i_endpoint_id;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_tdata;
    logic        o_tvalid;
    logic        o_tlast;
    logic [7:0]  o_tuser;
    logic        i_tready;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] model_ident;

    rdma_ipudp_header_gen dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .i_payload_len (i_payload_len),
        .i_src_ip      (i_src_ip),
        .i_dst_ip      (i_dst_ip),
        .i_src_port    (i_src_port),
        .i_dst_port    (i_dst_port),
        .i_flags       (i_flags),
        .i_endpoint_id (i_endpoint_id),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_tdata       (o_tdata),
        .o_tvalid      (o_tvalid),
        .o_tlast       (o_tlast),
        .o_tuser       (o_tuser),
        .i_tready      (i_tready)
    );

    always #5 iClk = ~iClk;

    function automatic logic [31:0] exp_word(input int idx, input logic [15:0] len,
                                             input logic [31:0] sip, input logic [31:0] dip,
                                             input logic [15:0] sp, input logic [15:0] dp,
                                             input logic [7:0] tos, input logic [15:0] ident);
        int unsigned s;
        logic [15:0] tot;
        logic [15:0] ulen;
        logic [15:0] cs;
        tot  = len + 16'd28;
        ulen = len + 16'd8;
        s = 32'h4500 + 32'(tos) + 32'(tot) + 32'(ident) + 32'h4000 + 32'h4011
            + 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        case (idx)
            0: return {8'h45, tos, tot};
            1: return {ident, 16'h4000};
            2: return {8'd64, 8'd17, cs};
            3: return sip;
            4: return dip;
            5: return {sp, dp};
            default: return {ulen, 16'h0000};
        endcase
    endfunction

    // Sends one record and consumes its header. Called and returns at a negedge.
    task automatic run_pkt(input logic [15:0] len, input logic [31:0] sip, input logic [31:0] dip,
                           input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] tos,
                           input logic [7:0] ep, input bit hold_valid, input int stall_word,
                           input int abort_word, input bit rand_stall);
        logic [31:0] ew [7];
        int k;
        int widx;
        int stall_left;
        int busy;
        bit tr;
        for (int i = 0; i < 7; i++) ew[i] = exp_word(i, len, sip, dip, sp, dp, tos, model_ident);
        k = 0;
        while (o_ready !== 1'b1 && k < 40) begin @(negedge iClk); k++; end
        n_cmp++;
        if (o_ready !== 1'b1) begin
            $display("FAIL ready_wait: o_ready=%b required 1 within 40 cycles", o_ready);
            n_err++;
            return;
        end
        i_payload_len = len; i_src_ip = sip; i_dst_ip = dip;
        i_src_port = sp; i_dst_port = dp; i_flags = tos; i_endpoint_id = ep;
        i_valid = 1'b1;
        @(negedge iClk);
        if (!hold_valid) begin
            i_valid = 1'b0;
            i_payload_len = 16'($urandom); i_src_ip = $urandom; i_dst_ip = $urandom;
            i_src_port = 16'($urandom); i_dst_port = 16'($urandom);
            i_flags = 8'($urandom); i_endpoint_id = 8'($urandom);
        end
        n_cmp++;
        if (o_ready !== 1'b0) begin
            $display("FAIL accept_ready_low: o_ready=%b required 0", o_ready);
            n_err++;
        end
        busy = 0;
        k = 0;
        while (o_tvalid !== 1'b1 && k < 20) begin
            if (o_ready !== 1'b0) busy++;
            @(negedge iClk);
            k++;
        end
        n_cmp++;
        if (k != 6) begin
            $display("FAIL latency: first tvalid after %0d cycles, required 6", k);
            n_err++;
        end
        if (o_tvalid !== 1'b1) return;
        widx = 0; stall_left = 3; k = 0;
        while (widx < 7 && k < 100) begin
            if (widx == abort_word) begin
                iRst = 1'b1;
                #1;
                n_cmp++;
                if (o_tvalid !== 1'b0 || o_tlast !== 1'b0 || o_ready !== 1'b0 || o_tdata !== 32'h0) begin
                    $display("FAIL async_abort: tvalid=%b tlast=%b ready=%b tdata=%h required 0 0 0 00000000",
                             o_tvalid, o_tlast, o_ready, o_tdata);
                    n_err++;
                end
                i_tready = 1'b1;
                $display("pkt aborted at word %0d ident=%h", widx, model_ident);
                return;
            end
            n_cmp++;
            if (o_tvalid !== 1'b1 || o_tdata !== ew[widx] || o_tlast !== (widx == 6) || o_tuser !== ep) begin
                $display("FAIL word%0d: tvalid=%b tdata=%h tlast=%b tuser=%h required 1 %h %b %h",
                         widx, o_tvalid, o_tdata, o_tlast, o_tuser, ew[widx], (widx == 6), ep);
                n_err++;
            end
            if (o_ready !== 1'b0) busy++;
            if (widx == stall_word && stall_left > 0) begin
                tr = 1'b0;
                stall_left--;
            end else if (rand_stall) begin
                tr = ($urandom_range(0, 3) != 0);
            end else begin
                tr = 1'b1;
            end
            i_tready = tr;
            @(negedge iClk);
            k++;
            if (tr) widx++;
        end
        i_tready = 1'b1;
        n_cmp++;
        if (widx < 7) begin
            $display("FAIL emit_timeout: %0d words consumed, required 7", widx);
            n_err++;
            return;
        end
        n_cmp++;
        if (o_tvalid !== 1'b0 || o_tlast !== 1'b0 || o_ready !== 1'b1) begin
            $display("FAIL post_packet: tvalid=%b tlast=%b ready=%b required 0 0 1", o_tvalid, o_tlast, o_ready);
            n_err++;
        end
        n_cmp++;
        if (busy != 0) begin
            $display("FAIL single_accept: o_ready high %0d cycles while busy, required 0", busy);
            n_err++;
        end
        $display("pkt ident=%h len=%0d ep=%h w2=%h", model_ident, len, ep, ew[2]);
        model_ident = model_ident + 16'd1;
    endtask

    task automatic test_reset();
        iRst = 1'b1; i_valid = 1'b0; i_tready = 1'b1;
        i_payload_len = '0; i_src_ip = '0; i_dst_ip = '0; i_src_port = '0;
        i_dst_port = '0; i_flags = '0; i_endpoint_id = '0;
        repeat (3) @(negedge iClk);
        n_cmp++;
        if (o_ready !== 1'b0 || o_tvalid !== 1'b0 || o_tlast !== 1'b0 || o_tdata !== 32'h0 || o_tuser !== 8'h0) begin
            $display("FAIL reset_outputs: ready=%b tvalid=%b tlast=%b tdata=%h tuser=%h required all 0",
                     o_ready, o_tvalid, o_tlast, o_tdata, o_tuser);
            n_err++;
        end
        iRst = 1'b0;
        #1;
        n_cmp++;
        if (o_ready !== 1'b0) begin
            $display("FAIL ready_before_edge: o_ready=%b required 0", o_ready);
            n_err++;
        end
        @(negedge iClk);
        n_cmp++;
        if (o_ready !== 1'b1) begin
            $display("FAIL ready_after_release: o_ready=%b required 1", o_ready);
            n_err++;
        end
        model_ident = 16'h0000;
    endtask

    task automatic test_known_packets();
        run_pkt(16'd100, 32'hC0A8010A, 32'hC0A80114, 16'h1234, 16'h5678, 8'h00, 8'h3C, 1'b0, -1, -1, 1'b0);
        run_pkt(16'd100, 32'hC0A8010A, 32'hC0A80114, 16'h1234, 16'h5678, 8'h00, 8'h3C, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_stall();
        run_pkt(16'd512, 32'h0A000001, 32'h0A0000FE, 16'hBEEF, 16'h12B7, 8'hB8, 8'hA5, 1'b0, 3, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [15:0] len;
            len = (i == 0) ? 16'd1 : (i == 1) ? 16'd1472 : 16'($urandom_range(1, 1472));
            run_pkt(len, $urandom, $urandom, 16'($urandom), 16'($urandom), 8'($urandom),
                    8'($urandom), 1'b0, -1, -1, 1'b1);
        end
    endtask

    task automatic test_ident_wrap();
        force dut.ident_q = 16'hFFFF;
        @(negedge iClk);
        @(negedge iClk);
        release dut.ident_q;
        model_ident = 16'hFFFF;
        run_pkt(16'd64, 32'h01020304, 32'h05060708, 16'h0001, 16'h0002, 8'h10, 8'h01, 1'b0, -1, -1, 1'b0);
        run_pkt(16'd64, 32'h01020304, 32'h05060708, 16'h0001, 16'h0002, 8'h10, 8'h02, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        run_pkt(16'd200, 32'hAC100001, 32'hAC100002, 16'h4321, 16'h8765, 8'h04, 8'h77, 1'b0, -1, 3, 1'b0);
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        model_ident = 16'h0000;
        @(negedge iClk);
        run_pkt(16'd200, 32'hAC100001, 32'hAC100002, 16'h4321, 16'h8765, 8'h04, 8'h78, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            run_pkt(16'd1000, 32'hC6336401, 32'hC6336402, 16'h2000, 16'h12B7, 8'h00, 8'h5A, 1'b1, -1, -1, 1'b0);
        i_valid = 1'b0;
        @(negedge iClk);
    endtask

    initial begin
        test_reset();
        test_known_packets();
        test_stall();
        test_random();
        test_ident_wrap();
        test_reset_mid_packet();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
